// File: rtl/isa_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM state encoding,
// requester count and the legal data-memory read latency range.
package isa_pkg;

  localparam int N_REQ       = 2;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester always wins, and on a tie the
// requester that was not granted last wins.
module rr_arbiter2
  import isa_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             last,
  output logic [N_REQ-1:0] pick
);

  always_comb begin
    pick = '0;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last ? 2'b01 : 2'b10;
      default: pick = '0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between the CPU load/store port (0) and the
// debug/DMA loader (1), one transaction at a time.
module mem_port_arbiter
  import isa_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int AW      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] we,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic [AW-1:0]    wdata0,
  input  logic [AW-1:0]    wdata1,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic [AW-1:0]    rdata,
  output logic             busy,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [AW-1:0]    mem_wdata,
  input  logic [AW-1:0]    mem_rdata,
  output state_e           state_dbg
);

  // Handshake: req is a level held by a requester until it sees gnt; gnt is a
  // one-cycle accept pulse in the issue cycle and done a one-cycle completion
  // pulse. Once granted, the transaction completes even if req drops, and
  // requests seen while not IDLE are only considered once IDLE is reached.

  state_e           state;
  logic [N_REQ-1:0] pick;
  logic             last;
  logic             win_q;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [AW-1:0]    wdata_q;
  logic [1:0]       cnt;
  logic             sel;

  rr_arbiter2 u_rr (
    .req  (req),
    .last (last),
    .pick (pick)
  );

  assign sel       = pick[1];
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      done    <= '0;
      busy    <= 1'b0;
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      rdata   <= '0;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
      last    <= 1'b1;
    end else begin
      gnt    <= '0;
      done   <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req != '0) begin
            win_q   <= sel;
            we_q    <= sel ? we[1] : we[0];
            addr_q  <= sel ? addr1 : addr0;
            wdata_q <= sel ? wdata1 : wdata0;
            mem_en  <= 1'b1;
            mem_we  <= sel ? we[1] : we[0];
            gnt     <= pick;
            busy    <= 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (we_q) begin
            done  <= idx_to_onehot(win_q);
            state <= ST_RESP;
          end else begin
            cnt   <= 2'(MEM_LAT - 1);
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // mem_rdata is valid in the last of the MEM_LAT wait cycles.
          if (cnt == '0) begin
            rdata <= mem_rdata;
            done  <= idx_to_onehot(win_q);
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          last  <= win_q;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1 and one at
// MEM_LAT=3, each attached to a small latency-accurate memory model.
module tb_mem_port_arbiter;
  import isa_pkg::*;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req_a = '0;
  logic [1:0]    req_b = '0;
  logic [1:0]    we = '0;
  logic [AW-1:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;

  logic [1:0]    g1, d1, g3, d3;
  logic [AW-1:0] rd1, rd3;
  logic          b1, b3, m1_en, m1_we, m3_en, m3_we;
  logic [AW-1:0] m1_addr, m1_wdata, m1_rdata, m3_addr, m3_wdata, m3_rdata;
  state_e        st1, st3;

  logic [AW-1:0] mem1 [256];
  logic [AW-1:0] mem3 [256];
  logic [AW-1:0] p1, p3a, p3b, p3c;

  int checks = 0;
  int failures = 0;
  logic [1:0]    exp_g;
  logic [AW-1:0] exp_a;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(1), .AW(AW)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req_a), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(g1), .done(d1), .rdata(rd1), .busy(b1),
    .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
    .mem_rdata(m1_rdata), .state_dbg(st1)
  );

  mem_port_arbiter #(.MEM_LAT(3), .AW(AW)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req_b), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(g3), .done(d3), .rdata(rd3), .busy(b3),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
    .mem_rdata(m3_rdata), .state_dbg(st3)
  );

  // Memory models: read data appears exactly MEM_LAT cycles after the issue
  // cycle and is zero otherwise, so a mistimed capture is visible.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= 16'(16'h1000 + i);
        mem3[i] <= 16'(16'h1000 + i);
      end
      mem3[5] <= 16'hBEEF;
    end else begin
      if (m1_en && m1_we) mem1[m1_addr[7:0]] <= m1_wdata;
      if (m3_en && m3_we) mem3[m3_addr[7:0]] <= m3_wdata;
    end
    p1  <= (m1_en && !m1_we) ? mem1[m1_addr[7:0]] : '0;
    p3a <= (m3_en && !m3_we) ? mem3[m3_addr[7:0]] : '0;
    p3b <= p3a;
    p3c <= p3b;
  end

  assign m1_rdata = p1;
  assign m3_rdata = p3c;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_busy", 16'(b1), 16'h0);
    chk("rst_gnt", 16'(g1), 16'h0);
    chk("rst_done", 16'(d1), 16'h0);
    chk("rst_mem_en", 16'(m1_en), 16'h0);
    chk("rst_rdata", rd1, 16'h0);
    chk("rst_mem_addr", m1_addr, 16'h0);
    tick(); tick(); tick();
    rst_n = 1'b1;

    // Tie on reads: requester 0 first, then strict alternation while both held
    we = 2'b00; addr0 = 16'h0010; addr1 = 16'h0020; req_a = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (k % 2 == 0) ? 16'h0010 : 16'h0020;
      tick();
      chk("rr_gnt", 16'(g1), 16'(exp_g));
      chk("rr_mem_en", 16'(m1_en), 16'h1);
      chk("rr_mem_we", 16'(m1_we), 16'h0);
      chk("rr_mem_addr", m1_addr, exp_a);
      chk("rr_busy", 16'(b1), 16'h1);
      tick();
      chk("rr_wait_gnt", 16'(g1), 16'h0);
      chk("rr_wait_en", 16'(m1_en), 16'h0);
      chk("rr_wait_done", 16'(d1), 16'h0);
      tick();
      chk("rr_done", 16'(d1), 16'(exp_g));
      chk("rr_rdata", rd1, 16'(16'h1000 + exp_a));
      if (k == 3) req_a = 2'b00;
      tick();
      chk("rr_idle_busy", 16'(b1), 16'h0);
      chk("rr_idle_done", 16'(d1), 16'h0);
      chk("rr_idle_state", 16'(st1), 16'(ST_IDLE));
    end

    // Write through requester 0 at MEM_LAT=1; rdata must keep 0x1020
    we = 2'b01; addr0 = 16'h0005; wdata0 = 16'hBEEF; req_a = 2'b01;
    tick();
    chk("wr_gnt", 16'(g1), 16'h1);
    chk("wr_mem_en", 16'(m1_en), 16'h1);
    chk("wr_mem_we", 16'(m1_we), 16'h1);
    chk("wr_mem_addr", m1_addr, 16'h0005);
    chk("wr_mem_wdata", m1_wdata, 16'hBEEF);
    req_a = 2'b00;
    tick();
    chk("wr_done", 16'(d1), 16'h1);
    chk("wr_rdata_held", rd1, 16'h1020);
    chk("wr_resp_en", 16'(m1_en), 16'h0);
    tick();
    chk("wr_idle_done", 16'(d1), 16'h0);

    // Read back from requester 0, dropping req the cycle after gnt
    we = 2'b00; req_a = 2'b01;
    tick();
    chk("drop_gnt", 16'(g1), 16'h1);
    req_a = 2'b00;
    tick();
    chk("drop_wait_done", 16'(d1), 16'h0);
    tick();
    chk("drop_done", 16'(d1), 16'h1);
    chk("drop_rdata", rd1, 16'hBEEF);
    tick();

    // Requester 0 was last granted, so a tie now goes to requester 1
    req_a = 2'b11;
    tick();
    chk("tie2_gnt", 16'(g1), 16'h2);
    chk("tie2_mem_addr", m1_addr, 16'h0020);
    req_a = 2'b00;
    tick(); tick();
    chk("tie2_done", 16'(d1), 16'h2);
    chk("tie2_rdata", rd1, 16'h1020);
    tick();

    // MEM_LAT=3 read by requester 1 from address 5 (memory holds 0xBEEF)
    we = 2'b00; addr1 = 16'h0005; req_b = 2'b10;
    tick();
    chk("l3_gnt", 16'(g3), 16'h2);
    chk("l3_mem_addr", m3_addr, 16'h0005);
    req_b = 2'b00;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("l3_wait_done", 16'(d3), 16'h0);
      chk("l3_wait_busy", 16'(b3), 16'h1);
    end
    tick();
    chk("l3_done", 16'(d3), 16'h2);
    chk("l3_rdata", rd3, 16'hBEEF);
    tick();

    // Requester 0 write at MEM_LAT=3 completes the cycle after issue
    we = 2'b01; addr0 = 16'h0030; wdata0 = 16'h1234; req_b = 2'b01;
    tick();
    chk("l3w_gnt", 16'(g3), 16'h1);
    chk("l3w_mem_we", 16'(m3_we), 16'h1);
    req_b = 2'b00;
    tick();
    chk("l3w_done", 16'(d3), 16'h1);
    chk("l3w_rdata_held", rd3, 16'hBEEF);
    tick();

    // Reset in the middle of a requester 1 read wait
    we = 2'b00; addr1 = 16'h0040; req_b = 2'b10;
    tick();
    chk("ab_gnt", 16'(g3), 16'h2);
    req_b = 2'b00;
    tick();
    chk("ab_in_wait", 16'(st3), 16'(ST_WAIT));
    #2;
    rst_n = 1'b0;
    #1;
    chk("ab_busy", 16'(b3), 16'h0);
    chk("ab_mem_en", 16'(m3_en), 16'h0);
    chk("ab_state", 16'(st3), 16'(ST_IDLE));
    chk("ab_rdata", rd3, 16'h0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ab_no_done", 16'(d3), 16'h0);
    end

    // Pointer is back at its reset value: a tie grants requester 0
    addr0 = 16'h0010; addr1 = 16'h0020; req_b = 2'b11;
    tick();
    chk("ab_tie_gnt", 16'(g3), 16'h1);
    chk("ab_tie_addr", m3_addr, 16'h0010);
    req_b = 2'b00;
    tick(); tick(); tick(); tick();
    chk("ab_tie_done", 16'(d3), 16'h1);
    chk("ab_tie_rdata", rd3, 16'h1010);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, data-memory read latency in cycles (legal 1..3).
REQ-002 SHALL have parameter AW, default 16, address and data width.
REQ-003 SHALL have port clk, input, 1, clock; rising-edge active.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port req, input, 2, per-requester access request (bit0 = CPU load/store port, bit1 = debug/DMA loader).
REQ-006 SHALL have port we, input, 2, per-requester write enable; valid while req is high.
REQ-007 SHALL have ports addr0/addr1, input, AW, per-requester address.
REQ-008 SHALL have ports wdata0/wdata1, input, AW, per-requester write data.
REQ-009 SHALL have port gnt, output, 2, one-hot grant pulse, high in the issue cycle.
REQ-010 SHALL have port done, output, 2, one-hot completion pulse, one cycle.
REQ-011 SHALL have port rdata, output, AW, registered read data, valid while done is high for a read.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have ports mem_en, mem_we (output, 1), mem_addr, mem_wdata (output, AW), mem_rdata (input, AW): the single data-memory port.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT and RESP.
REQ-015 IDLE: when req != 0 at a clock edge, SHALL select the winner, latch its we/addr/wdata, and enter ISSUE.
REQ-016 Winner selection SHALL be two-way round-robin: on simultaneous requests, the requester not granted last wins; a single requester always wins.
REQ-017 ISSUE (cycle T): SHALL drive mem_en=1, mem_we, mem_addr and mem_wdata from the latched fields and raise gnt[winner].
REQ-018 For a write, ISSUE SHALL go to RESP, so done[winner] is high in cycle T+1.
REQ-019 For a read, ISSUE SHALL go to WAIT for MEM_LAT cycles (T+1..T+MEM_LAT), using a latency counter.
REQ-020 In the last WAIT cycle, SHALL load rdata from mem_rdata and then enter RESP, so done[winner] is high in cycle T+MEM_LAT+1.
REQ-021 RESP SHALL pulse done[winner], update the last-granted pointer, and return to IDLE; one IDLE cycle always separates transactions.
REQ-022 Outside ISSUE, mem_en and mem_we SHALL be 0; gnt and done SHALL never have more than one bit set.
REQ-023 rdata SHALL hold its value until the next read capture; a write SHALL not alter rdata.
REQ-024 A requester dropping req after grant SHALL not abort the transaction; done is still pulsed.
REQ-025 A requester whose req stays high after its done SHALL be treated as a new request in IDLE.
REQ-026 Requests arriving outside IDLE SHALL be ignored until IDLE; there is no queueing inside the block.
REQ-027 Address and data SHALL pass through unmodified; there is no range check.

Reset
REQ-028 Asserting rst_n low SHALL immediately (asynchronously) set the state to IDLE and clear gnt, done, busy, mem_en and mem_we.
REQ-029 Reset SHALL clear rdata, the latched fields and the counter to 0, and set the last-granted pointer to 1 so requester 0 wins the first tie.
REQ-030 Reset mid-transaction SHALL abort it with no done pulse.

Structure
REQ-031 State encoding, the requester-count constant (2) and the MEM_LAT legal range SHALL live in shared package isa_pkg.
REQ-032 Winner selection SHALL be a sub-module rr_arbiter2 (inputs req and last; output one-hot pick), purely combinational.

Verification
REQ-033 Scenario: after reset, req=2'b11, both reads, addr0=0x0010, addr1=0x0020 -> gnt=01 with mem_addr=0x0010 first, then gnt=10 with mem_addr=0x0020.
REQ-034 Scenario: MEM_LAT=1, req0 write addr=0x0005 wdata=0xBEEF in IDLE cycle T-1 -> mem_en=mem_we=1 in T, done=01 in T+1, rdata unchanged.
REQ-035 Scenario: MEM_LAT=3, req1 read addr=0x0005 with memory returning 0xBEEF -> done=10 in T+4 with rdata=0xBEEF.
REQ-036 Scenario: req0 held high continuously while req1 is high -> grants alternate 01, 10, 01, 10 with no starvation.
REQ-037 Scenario: rst_n low during WAIT -> busy=0 and mem_en=0 immediately; no done pulse; the next tie grants requester 0.
REQ-038 Scenario: req0 dropped in the cycle after gnt -> done=01 still pulses at the required cycle.
